// File: rtl/power_sequencer.sv
// Board power sequencer: brings the rails up in order, warns the host on a shutdown
// request, then ramps the rails down in reverse order and drops the supply latch.
module power_sequencer #(
  parameter int TICK_DIV    = 50000,
  parameter int NRAILS      = 3,
  parameter int RAIL_GAP_MS = 10,
  parameter int WARN_MS     = 2000,
  parameter int DEB_MS      = 20,
  parameter int LONG_MS     = 3000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              off_req,
  input  logic              btn_n,
  input  logic              host_ack,
  output logic [NRAILS-1:0] rail_en,
  output logic              pwr_hold,
  output logic              warn,
  output logic [2:0]        state_o
);

  localparam int PW   = $clog2(TICK_DIV + 1);
  localparam int DW   = $clog2(DEB_MS + 1);
  localparam int LW   = $clog2(LONG_MS + 1);
  localparam int KW   = $clog2(NRAILS + 1);
  localparam int TMAX = (RAIL_GAP_MS > WARN_MS) ? RAIL_GAP_MS : WARN_MS;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WARN    = 3'd2,
    ST_RAMP    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic [1:0]    rst_sync_reg;
  logic          run;
  logic [PW-1:0] presc_reg;
  logic          tick;
  logic [1:0]    btn_sync_reg;
  logic          raw_pressed;
  logic          deb_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          deb_flip;
  logic [LW-1:0] press_cnt_reg;
  logic          long_evt_reg;
  logic          short_evt_reg;

  state_t            state_reg, state_next;
  logic [TW-1:0]     cnt_reg, cnt_next;
  logic [KW-1:0]     k_reg, k_next;
  logic [NRAILS-1:0] rail_next;
  logic              gap_done;

  // Everything stays in its reset value until the release has passed two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= 2'b00;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign run = rst_sync_reg[1];

  assign tick = run && (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   presc_reg <= '0;
    else if (run) presc_reg <= tick ? '0 : presc_reg + 1'b1;
  end

  assign raw_pressed = ~btn_sync_reg[1];
  assign deb_flip    = tick && (raw_pressed != deb_reg) && (deb_cnt_reg == DW'(DEB_MS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync_reg  <= 2'b11;
      deb_reg       <= 1'b0;
      deb_cnt_reg   <= '0;
      press_cnt_reg <= '0;
      long_evt_reg  <= 1'b0;
      short_evt_reg <= 1'b0;
    end else if (run) begin
      btn_sync_reg  <= {btn_sync_reg[0], btn_n};
      long_evt_reg  <= 1'b0;
      short_evt_reg <= 1'b0;
      if (raw_pressed == deb_reg) deb_cnt_reg <= '0;
      else if (tick)              deb_cnt_reg <= deb_flip ? '0 : deb_cnt_reg + 1'b1;
      if (deb_flip) deb_reg <= raw_pressed;
      // Press timer saturates at LONG_MS so a release after a long press is not short.
      if (deb_reg && deb_flip) begin
        press_cnt_reg <= '0;
        short_evt_reg <= (press_cnt_reg != LW'(LONG_MS));
      end else if (deb_reg && tick && (press_cnt_reg != LW'(LONG_MS))) begin
        press_cnt_reg <= press_cnt_reg + 1'b1;
        long_evt_reg  <= (press_cnt_reg == LW'(LONG_MS - 1));
      end
    end
  end

  assign gap_done = tick && (cnt_reg == TW'(RAIL_GAP_MS - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    k_next     = k_reg;
    rail_next  = rail_en;
    case (state_reg)
      ST_START: begin
        if (tick) begin
          if (k_reg == KW'(NRAILS)) begin
            state_next = ST_IDLE;
          end else if (gap_done) begin
            for (int i = 0; i < NRAILS; i++)
              if (k_reg == KW'(i)) rail_next[i] = 1'b1;
            k_next   = k_reg + 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_IDLE: begin
        rail_next = '1;
        if (long_evt_reg)                 state_next = ST_RAMP;
        else if (off_req || short_evt_reg) state_next = ST_WARN;
      end
      ST_WARN: begin
        if (host_ack || long_evt_reg || (tick && (cnt_reg == TW'(WARN_MS - 1))))
          state_next = ST_RAMP;
        else if (tick)
          cnt_next = cnt_reg + 1'b1;
      end
      ST_RAMP: begin
        if (gap_done) begin
          cnt_next = '0;
          if (k_reg == KW'(NRAILS)) begin
            state_next = ST_RELEASE;
          end else begin
            for (int i = 0; i < NRAILS; i++)
              if (k_reg == KW'(NRAILS - 1 - i)) rail_next[i] = 1'b0;
            k_next = k_reg + 1'b1;
          end
        end else if (tick) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_RELEASE: rail_next = '0;
      default:    state_next = ST_START;
    endcase
    // Each state starts with a fresh timer and rail index.
    if (state_next != state_reg) begin
      cnt_next = '0;
      k_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_START;
      cnt_reg   <= '0;
      k_reg     <= '0;
      rail_en   <= '0;
      warn      <= 1'b0;
      pwr_hold  <= 1'b1;
    end else if (run) begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      k_reg     <= k_next;
      rail_en   <= rail_next;
      warn      <= (state_next == ST_WARN);
      pwr_hold  <= (state_next != ST_RELEASE);
    end
  end

  assign state_o = state_reg;

endmodule

// File: tb/tb_power_sequencer.sv
// Bench for power_sequencer: directed scenarios with literal timing checks plus randomized
// traffic compared every cycle against a tick-counting behavioural model.
module tb_power_sequencer;
  localparam int TD = 4, NR = 3, GAP = 2, WMS = 10, DEB = 3, LONG = 20;

  logic clk = 1'b0, rst_n = 1'b0, off_req = 1'b0, btn_n = 1'b1, host_ack = 1'b0;
  logic [NR-1:0] rail_en;
  logic pwr_hold, warn;
  logic [2:0] state_o;

  int tests = 0, fails = 0;
  bit chk_en = 1'b0;

  power_sequencer #(.TICK_DIV(TD), .NRAILS(NR), .RAIL_GAP_MS(GAP), .WARN_MS(WMS),
                    .DEB_MS(DEB), .LONG_MS(LONG)) dut (
    .clk(clk), .rst_n(rst_n), .off_req(off_req), .btn_n(btn_n), .host_ack(host_ack),
    .rail_en(rail_en), .pwr_hold(pwr_hold), .warn(warn), .state_o(state_o));

  always #5 clk = ~clk;

  // Model: state plus ticks spent in it; rails are derived from elapsed ticks.
  int m_state, m_t, m_rs, m_cyc, m_dis, m_press;
  bit m_deb, m_long, m_short, m_h0, m_h1;

  task automatic model_reset();
    m_state = 0; m_t = 0; m_rs = 0; m_cyc = 0; m_dis = 0; m_press = 0;
    m_deb = 0; m_long = 0; m_short = 0; m_h0 = 1; m_h1 = 1;
  endtask

  task automatic model_step();
    bit tick, raw, lo, sh, flip;
    int nxt, tn;
    if (m_rs < 2) begin m_rs++; return; end
    tick = ((m_cyc % TD) == TD - 1);
    m_cyc++;
    raw = !m_h1; m_h1 = m_h0; m_h0 = btn_n;
    lo = m_long; sh = m_short;
    tn = tick ? m_t + 1 : m_t;
    nxt = m_state;
    case (m_state)
      0: if (tick && tn == NR * GAP + 1) nxt = 1;
      1: if (lo) nxt = 3; else if (off_req || sh) nxt = 2;
      2: if (host_ack || lo || (tick && tn == WMS)) nxt = 3;
      3: if (tick && tn == (NR + 1) * GAP) nxt = 4;
      default: ;
    endcase
    m_t = (nxt != m_state) ? 0 : tn;
    m_state = nxt;
    m_long = 0; m_short = 0; flip = 0;
    if (raw == m_deb) m_dis = 0;
    else if (tick) begin
      m_dis++;
      if (m_dis == DEB) begin flip = 1; m_dis = 0; end
    end
    if (flip && m_deb) begin m_short = (m_press < LONG); m_press = 0; end
    else if (m_deb && tick) begin m_press++; m_long = (m_press == LONG); end
    if (flip) m_deb = raw;
  endtask

  function automatic logic [2:0] exp_rails(input int st, input int t);
    int n, v;
    logic [2:0] r;
    n = t / GAP;
    if (n > NR) n = NR;
    case (st)
      0: v = n;
      1, 2: v = NR;
      3: v = NR - n;
      default: v = 0;
    endcase
    v = (1 << v) - 1;
    r = v[2:0];
    return r;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    logic [2:0] er;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        er = exp_rails(m_state, m_t);
        tests++;
        if (rail_en !== er || pwr_hold !== (m_state != 4) || warn !== (m_state == 2) ||
            state_o !== m_state[2:0]) begin
          fails++;
          $display("FAIL model t=%0t: rail_en=%b pwr_hold=%b warn=%b state=%0d, required %b %b %b %0d",
                   $time, rail_en, pwr_hold, warn, state_o, er, m_state != 4, m_state == 2, m_state);
        end
      end
    end
  end

  task automatic nx();
    @(negedge clk); #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    nx();
    rst_n = 1'b0; off_req = 1'b0; host_ack = 1'b0; btn_n = 1'b1;
    #1;
    check("reset rail_en", rail_en, 0);
    check("reset pwr_hold", pwr_hold, 1);
    check("reset warn", warn, 0);
    check("reset state", state_o, 0);
    chk_en = 1'b1;
    repeat (2) nx();
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input string name, input int s, input int max, output int n);
    n = 0;
    while (state_o != s[2:0] && n < max) begin nx(); n++; end
    check(name, state_o, s);
  endtask

  // Expects three rail changes, 8 cycles apart, in up (001,011,111) or down (011,001,000) order.
  task automatic track_rails(input bit up, input string tag);
    logic [2:0] last;
    int idx, c, last_c, ev;
    last = rail_en; idx = 0; c = 0; last_c = 0;
    while (idx < 3 && c < 80) begin
      nx(); c++;
      if (rail_en != last) begin
        ev = up ? ((1 << (idx + 1)) - 1) : (7 >> (idx + 1));
        check({tag, " value"}, rail_en, ev);
        if (idx > 0) check({tag, " spacing"}, c - last_c, 8);
        last_c = c; last = rail_en; idx++;
      end
    end
    check({tag, " steps"}, idx, 3);
  endtask

  task automatic rand_trial();
    int off_at, seg;
    logic b;
    off_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 400);
    seg = 0; b = 1'b1;
    do_reset();
    for (int c = 0; c < 450; c++) begin
      if (seg == 0) begin
        b = ($urandom_range(0, 2) != 0);
        seg = $urandom_range(1, 120);
      end
      seg--;
      btn_n = b;
      off_req = (c >= off_at);
      host_ack = ($urandom_range(0, 59) == 0);
      nx();
    end
  endtask

  initial begin
    int n, bad;
    bit wseen;
    // 1: power-up ordering
    do_reset();
    track_rails(1'b1, "s1 rampup");
    wait_state("s1 idle", 1, 20, n);
    check("s1 pwr_hold", pwr_hold, 1);
    // 2: off_req, no ack -> timeout -> ramp -> release
    off_req = 1'b1;
    nx();
    check("s2 warn next", warn, 1);
    check("s2 state warn", state_o, 2);
    wait_state("s2 ramp", 3, 60, n);
    check_range("s2 warn cycles", n, 36, 44);
    check("s2 warn off", warn, 0);
    track_rails(1'b0, "s2 rampdown");
    wait_state("s2 release", 4, 20, n);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      nx();
      if (pwr_hold !== 1'b0 || state_o !== 3'd4 || rail_en !== 3'b000) bad++;
    end
    check("s2 release held", bad, 0);
    // 3: host ack shortcuts the timeout
    do_reset();
    wait_state("s3 idle", 1, 60, n);
    off_req = 1'b1;
    repeat (12) nx();
    check("s3 still warn", state_o, 2);
    host_ack = 1'b1;
    nx();
    host_ack = 1'b0;
    check("s3 ack ramp", state_o, 3);
    check("s3 warn off", warn, 0);
    track_rails(1'b0, "s3 rampdown");
    // 4: short press -> WARN
    do_reset();
    wait_state("s4 idle", 1, 60, n);
    btn_n = 1'b0;
    repeat (32) nx();
    btn_n = 1'b1;
    wait_state("s4 short warn", 2, 60, n);
    // 5: one-tick glitches are filtered
    do_reset();
    wait_state("s5 idle", 1, 60, n);
    repeat (10) begin
      btn_n = 1'b0; repeat (4) nx();
      btn_n = 1'b1; repeat (12) nx();
    end
    repeat (40) nx();
    check("s5 glitch state", state_o, 1);
    // 6: long press -> RAMP without warning
    do_reset();
    wait_state("s6 idle", 1, 60, n);
    btn_n = 1'b0;
    n = 0; wseen = 0;
    while (state_o != 3'd3 && n < 150) begin
      nx(); n++;
      if (warn) wseen = 1;
    end
    check("s6 long ramp", state_o, 3);
    check("s6 warn seen", wseen, 0);
    check_range("s6 long cycles", n, 85, 100);
    btn_n = 1'b1;
    // 7: reset mid-RAMP and in RELEASE
    do_reset();
    wait_state("s7 idle", 1, 60, n);
    off_req = 1'b1;
    nx();
    host_ack = 1'b1; nx(); host_ack = 1'b0;
    n = 0;
    while (!(state_o == 3'd3 && rail_en == 3'b001) && n < 60) begin nx(); n++; end
    check("s7 ramp rail001", rail_en, 1);
    do_reset();
    track_rails(1'b1, "s7 reseq1");
    wait_state("s7 idle2", 1, 20, n);
    off_req = 1'b1;
    wait_state("s7 release", 4, 200, n);
    do_reset();
    track_rails(1'b1, "s7 reseq2");
    wait_state("s7 idle3", 1, 20, n);
    // randomized traffic against the model
    for (int t = 0; t < 25; t++) rand_trial();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/power_sequencer.md
Name: power_sequencer

Overview:
- Downstream consumer of the power-off countdown block's pwr_off level. Also takes the front-panel button and a host acknowledge.
- Brings the board rails up in order after reset and holds the supply latch.
- On a shutdown request, warns the host, waits for its ack or a timeout, then drops the rails in reverse order and finally releases the supply latch.

Parameters:
- TICK_DIV, 50000: clk cycles per 1 ms tick (50 MHz clock).
- NRAILS, 3: number of sequenced rail enables (1..8).
- RAIL_GAP_MS, 10: ticks between successive rail transitions.
- WARN_MS, 2000: host ack timeout in WARN, in ticks.
- DEB_MS, 20: button debounce stability time, in ticks.
- LONG_MS, 3000: press duration that forces immediate shutdown, in ticks.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- off_req, input, 1: level shutdown request from the power-off countdown block's pwr_off.
- btn_n, input, 1: raw power button, active low, asynchronous.
- host_ack, input, 1: one-cycle host acknowledge of the warning.
- rail_en, output, NRAILS: rail enables. Bit 0 comes up first and goes down last.
- pwr_hold, output, 1: supply keep-alive latch. 1 = stay powered.
- warn, output, 1: shutdown-pending interrupt to the host.
- state_o, output, 3: current state encoding (START=0, IDLE=1, WARN=2, RAMP=3, RELEASE=4).

Behaviour:
- Reset (async assert, sync-released internally via 2-flop): rail_en=0, pwr_hold=1, warn=0, state=START, all counters 0. Reset mid-RAMP or in RELEASE restarts at START.
- Tick: free-running prescaler counts 0..TICK_DIV-1 and emits a 1-cycle tick at wrap. All ms timers advance only on tick, so accuracy is -1/+0 tick.
- Button path:
  - 2-flop synchronizer, then debouncer. The debounced level changes only after the raw synced level differs from it for DEB_MS consecutive ticks.
  - Press timer counts ticks while debounced level is pressed. It reaching LONG_MS gives a 1-cycle long_evt, at the moment of reaching, not on release.
  - Debounced release with timer < LONG_MS gives a 1-cycle short_evt.
  - Timer clears on release.
- START:
  - Rail index k goes 0..NRAILS-1. rail_en[k] sets after RAIL_GAP_MS ticks from entry (k=0) or from the previous rail.
  - After the last rail is set, go to IDLE on the next tick boundary.
  - Button events and off_req are ignored during START.
- IDLE:
  - rail_en all 1, pwr_hold=1, warn=0.
  - long_evt → RAMP.
  - Else off_req==1 (level) or short_evt → WARN.
  - host_ack ignored.
- WARN:
  - warn=1. Ack timer cleared on entry.
  - host_ack → RAMP.
  - Timer reaching WARN_MS → RAMP.
  - long_evt → RAMP.
  - short_evt ignored.
  - warn drops to 0 on leaving WARN.
- RAMP:
  - Clears rail_en[NRAILS-1] down to rail_en[0], one per RAIL_GAP_MS ticks; first clear comes RAIL_GAP_MS ticks after entry.
  - RAIL_GAP_MS ticks after rail_en[0] clears → RELEASE.
  - All inputs ignored.
- RELEASE: pwr_hold=0, rail_en=0, warn=0. Terminal until reset.
- Simultaneous events:
  - long_evt and off_req in the same IDLE cycle → RAMP (long press wins).
  - host_ack and timeout in the same cycle → RAMP (same result).
- off_req already high at reset release: START completes normally, then IDLE goes to WARN one cycle after entry.
- All outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
Bench parameters: TICK_DIV=4, NRAILS=3, RAIL_GAP_MS=2, WARN_MS=10, DEB_MS=3, LONG_MS=20.
1. Release rst_n, all inputs idle → rail_en steps 001, 011, 111 at 8-cycle spacing (±1 tick). state_o=1. pwr_hold=1 throughout.
2. In IDLE, raise off_req, never ack → warn=1 next cycle. After 10 ticks (40±4 cycles) state=RAMP and warn=0. rail_en goes 011, 001, 000 at 8-cycle spacing. Then pwr_hold=0 and state_o=4, held for 200 cycles.
3. In IDLE, off_req → WARN, then host_ack pulse at tick 3 → RAMP on the next cycle, no timeout wait. Same ramp-down ordering as scenario 2.
4. In IDLE, btn_n low for 8 ticks then high → short_evt → WARN.
5. Bounce btn_n for 1-tick glitches → no state change.
6. In IDLE, btn_n held low → RAMP at debounce + 20 ticks, with warn never asserted.
7. Reset mid-RAMP (rail_en=001) → rail_en=000 and pwr_hold=1 asynchronously, then START re-sequences. Repeat reset in RELEASE → recovers identically.
